// File: rtl/wb_dfltslv.sv
// Default wishbone slave: catches accesses to unmapped space, records the
// first fault, counts faults, pulses irq, and either halts simulation or
// completes the access with a fixed read value after ACKLAT cycles.
module wb_dfltslv #(
   parameter int                   ARCHBITSZ = 32,
   parameter logic [ARCHBITSZ-1:0] MAPSZ     = 'h1000,
   parameter int                   MODE      = 0,
   parameter int                   ACKLAT    = 1,
   parameter logic [ARCHBITSZ-1:0] DFLTDAT   = 'hdeadbeef,
   parameter int                   CNTBITSZ  = 8,
   localparam int                  SELBITSZ  = ARCHBITSZ / 8,
   localparam int                  OFFBITSZ  = $clog2(SELBITSZ),
   localparam int                  ADDRBITSZ = ARCHBITSZ - OFFBITSZ
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 wb_cyc_i,
   input  logic                 wb_stb_i,
   input  logic                 wb_we_i,
   input  logic [ADDRBITSZ-1:0] wb_addr_i,
   input  logic [SELBITSZ-1:0]  wb_sel_i,
   input  logic [ARCHBITSZ-1:0] wb_dat_i,
   output logic                 wb_bsy_o,
   output logic                 wb_ack_o,
   output logic [ARCHBITSZ-1:0] wb_dat_o,
   output logic [ARCHBITSZ-1:0] wb_mapsz_o,
   input  logic                 clr_i,
   output logic                 flt_o,
   output logic [ARCHBITSZ-1:0] fltaddr_o,
   output logic                 fltwe_o,
   output logic [SELBITSZ-1:0]  fltsel_o,
   output logic [CNTBITSZ-1:0]  fltcnt_o,
   output logic                 irq_o
);

   // Halting only makes sense in a simulator; in hardware MODE 0 behaves as MODE 1.
`ifdef SIMULATION
   localparam bit SIM = 1'b1;
`else
   localparam bit SIM = 1'b0;
`endif
   localparam bit HALT = SIM && (MODE == 0);

   typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

   state_t                 state_q, state_d;
   logic [3:0]             lat_q, lat_d;
   logic                   we_q, we_d;
   logic                   bsy_q, bsy_d;
   logic                   ack_q, ack_d;
   logic [ARCHBITSZ-1:0]   dat_q, dat_d;
   logic                   irq_q, irq_d;
   logic                   flt_q, flt_d;
   logic [ARCHBITSZ-1:0]   fltaddr_q, fltaddr_d;
   logic                   fltwe_q, fltwe_d;
   logic [SELBITSZ-1:0]    fltsel_q, fltsel_d;
   logic [CNTBITSZ-1:0]    fltcnt_q, fltcnt_d;
   logic                   accept;
   logic [ARCHBITSZ-1:0]   byteaddr;

   // Write data is never stored; fold it away so it does not dangle.
   logic unused_wrdat;
   assign unused_wrdat = ^wb_dat_i;

   assign accept   = wb_cyc_i & wb_stb_i & ~bsy_q;
   assign byteaddr = {wb_addr_i, {OFFBITSZ{1'b0}}};

   // Next-state: access FSM with latency countdown, plus fault record/counter.
   always_comb begin
      state_d   = state_q;
      lat_d     = lat_q;
      we_d      = we_q;
      flt_d     = flt_q;
      fltaddr_d = fltaddr_q;
      fltwe_d   = fltwe_q;
      fltsel_d  = fltsel_q;
      fltcnt_d  = fltcnt_q;
      irq_d     = accept;

      case (state_q)
         IDLE: begin
            if (accept && !HALT) begin
               we_d = wb_we_i;
               // The accept cycle itself counts as the first latency cycle.
               if (ACKLAT == 1) begin
                  state_d = ACK;
               end else begin
                  state_d = WAIT;
                  lat_d   = 4'(ACKLAT - 2);
               end
            end
         end
         WAIT: begin
            // Master gave up: drop the access without acking.
            if (!wb_cyc_i)          state_d = IDLE;
            else if (lat_q == 4'd0) state_d = ACK;
            else                    lat_d   = lat_q - 4'd1;
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      bsy_d = (state_d != IDLE);
      ack_d = (state_d == ACK);
      dat_d = (ack_d && !we_d) ? DFLTDAT : '0;

      // Clear first so that a simultaneous accept re-records the new access.
      if (clr_i) begin
         flt_d     = 1'b0;
         fltaddr_d = '0;
         fltwe_d   = 1'b0;
         fltsel_d  = '0;
         fltcnt_d  = '0;
      end
      if (accept) begin
         if (!flt_d) begin
            fltaddr_d = byteaddr;
            fltwe_d   = wb_we_i;
            fltsel_d  = wb_sel_i;
         end
         flt_d = 1'b1;
         if (fltcnt_d != {CNTBITSZ{1'b1}}) fltcnt_d = fltcnt_d + 1'b1;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         lat_q     <= '0;
         we_q      <= 1'b0;
         bsy_q     <= 1'b0;
         ack_q     <= 1'b0;
         dat_q     <= '0;
         irq_q     <= 1'b0;
         flt_q     <= 1'b0;
         fltaddr_q <= '0;
         fltwe_q   <= 1'b0;
         fltsel_q  <= '0;
         fltcnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         lat_q     <= lat_d;
         we_q      <= we_d;
         bsy_q     <= bsy_d;
         ack_q     <= ack_d;
         dat_q     <= dat_d;
         irq_q     <= irq_d;
         flt_q     <= flt_d;
         fltaddr_q <= fltaddr_d;
         fltwe_q   <= fltwe_d;
         fltsel_q  <= fltsel_d;
         fltcnt_q  <= fltcnt_d;
      end
   end

`ifdef SIMULATION
   // Halt mode: report the offending byte address and stop the simulation.
   always_ff @(posedge clk_i) begin
      if (!rst_i && accept && HALT) begin
         $write("wb_dfltslv: access to unmapped address 0x%h\n", byteaddr);
         $finish;
      end
   end
`endif

   assign wb_bsy_o   = bsy_q;
   assign wb_ack_o   = ack_q;
   assign wb_dat_o   = dat_q;
   assign wb_mapsz_o = MAPSZ;
   assign flt_o      = flt_q;
   assign fltaddr_o  = fltaddr_q;
   assign fltwe_o    = fltwe_q;
   assign fltsel_o   = fltsel_q;
   assign fltcnt_o   = fltcnt_q;
   assign irq_o      = irq_q;

endmodule

// File: tb/tb_wb_dfltslv.sv
// Bench for wb_dfltslv: three instances (ACKLAT 1/4/3, counter 2/8/8 bits),
// a time-since-accept model checked every cycle, plus directed literal checks.
module tb_wb_dfltslv;

   localparam logic [31:0] DEAD = 32'hdeadbeef;

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : ((k == 1) ? 4 : 3);
   endfunction
   function automatic int cmax_of(input int k);
      return (k == 0) ? 3 : 255;
   endfunction

   logic       clk = 1'b0;
   logic [2:0] rst, cyc, stb, we, clr;
   logic [29:0] addr [3];
   logic [3:0]  sel  [3];
   logic [31:0] wdat [3];
   logic [2:0] bsy, ack, flt, fltwe, irq;
   logic [31:0] dato [3];
   logic [31:0] mapsz [3];
   logic [31:0] fltaddr [3];
   logic [3:0]  fltsel [3];
   logic [7:0]  fltcnt [3];

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int CB = (g == 0) ? 2 : 8;
      logic [CB-1:0] cnt_l;
      assign fltcnt[g] = 8'(cnt_l);
      wb_dfltslv #(
         .ARCHBITSZ(32), .MAPSZ(32'h1000), .MODE(1),
         .ACKLAT((g == 0) ? 1 : ((g == 1) ? 4 : 3)),
         .DFLTDAT(32'hdeadbeef), .CNTBITSZ(CB)
      ) u_dut (
         .clk_i(clk), .rst_i(rst[g]),
         .wb_cyc_i(cyc[g]), .wb_stb_i(stb[g]), .wb_we_i(we[g]),
         .wb_addr_i(addr[g]), .wb_sel_i(sel[g]), .wb_dat_i(wdat[g]),
         .wb_bsy_o(bsy[g]), .wb_ack_o(ack[g]), .wb_dat_o(dato[g]),
         .wb_mapsz_o(mapsz[g]), .clr_i(clr[g]), .flt_o(flt[g]),
         .fltaddr_o(fltaddr[g]), .fltwe_o(fltwe[g]), .fltsel_o(fltsel[g]),
         .fltcnt_o(cnt_l), .irq_o(irq[g])
      );
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Model: an access is pending from accept until it has aged ACKLAT cycles
   // (ack in that last cycle), or until cyc drops while still waiting.
   bit          m_pend [3];
   int          m_age  [3];
   bit          m_rd   [3];
   bit          m_acc;
   logic        e_bsy [3], e_ack [3], e_irq [3], e_flt [3], e_we [3];
   logic [31:0] e_dat [3], e_addr [3];
   logic [3:0]  e_sel [3];
   int          e_cnt [3];

   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (rst[k]) begin
            m_pend[k] = 0; m_age[k] = 0; m_rd[k] = 0;
            e_bsy[k] = 0; e_ack[k] = 0; e_irq[k] = 0; e_dat[k] = 0;
            e_flt[k] = 0; e_addr[k] = 0; e_we[k] = 0; e_sel[k] = 0; e_cnt[k] = 0;
         end else begin
            m_acc = cyc[k] && stb[k] && !e_bsy[k];
            if (m_pend[k]) begin
               if (m_age[k] == lat_of(k)) m_pend[k] = 0;
               else if (!cyc[k])          m_pend[k] = 0;
               else                       m_age[k]++;
            end
            if (m_acc) begin
               m_pend[k] = 1; m_age[k] = 1; m_rd[k] = !we[k];
            end
            e_bsy[k] = m_pend[k];
            e_ack[k] = m_pend[k] && (m_age[k] == lat_of(k));
            e_dat[k] = (e_ack[k] && m_rd[k]) ? DEAD : 32'h0;
            e_irq[k] = m_acc;
            if (clr[k]) begin
               e_flt[k] = 0; e_addr[k] = 0; e_we[k] = 0; e_sel[k] = 0; e_cnt[k] = 0;
            end
            if (m_acc) begin
               if (!e_flt[k]) begin
                  e_addr[k] = {addr[k], 2'b00}; e_we[k] = we[k]; e_sel[k] = sel[k];
               end
               e_flt[k] = 1;
               if (e_cnt[k] < cmax_of(k)) e_cnt[k]++;
            end
         end
      end
   end

   // Compare every output of every instance against the model each cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("dut%0d bsy", k), 64'(bsy[k]), 64'(e_bsy[k]));
            chk($sformatf("dut%0d ack", k), 64'(ack[k]), 64'(e_ack[k]));
            chk($sformatf("dut%0d dat", k), 64'(dato[k]), 64'(e_dat[k]));
            chk($sformatf("dut%0d irq", k), 64'(irq[k]), 64'(e_irq[k]));
            chk($sformatf("dut%0d flt", k), 64'(flt[k]), 64'(e_flt[k]));
            chk($sformatf("dut%0d fltaddr", k), 64'(fltaddr[k]), 64'(e_addr[k]));
            chk($sformatf("dut%0d fltwe", k), 64'(fltwe[k]), 64'(e_we[k]));
            chk($sformatf("dut%0d fltsel", k), 64'(fltsel[k]), 64'(e_sel[k]));
            chk($sformatf("dut%0d fltcnt", k), 64'(fltcnt[k]), 64'(e_cnt[k]));
            chk($sformatf("dut%0d mapsz", k), 64'(mapsz[k]), 64'h1000);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   initial begin
      int exp_cnt [5];
      exp_cnt = '{1, 2, 3, 3, 3};
      rst = 3'b111; cyc = '0; stb = '0; we = '0; clr = '0;
      for (int k = 0; k < 3; k++) begin
         addr[k] = '0; sel[k] = '0; wdat[k] = 32'h12345678;
      end
      step(); chk_en = 1'b1;
      neg(); chk("rst bsy", 64'(bsy), 64'h0); chk("rst fltcnt", 64'(fltcnt[0]), 64'h0);
      step(); rst = '0;

      // T1: ACKLAT1 read of word 0x40
      step(); cyc[0] = 1; stb[0] = 1; we[0] = 0; addr[0] = 30'h40; sel[0] = 4'hf;
      neg(); chk("t1 bsy@T", 64'(bsy[0]), 64'h0);
      step(); cyc[0] = 0; stb[0] = 0;
      neg();
      chk("t1 bsy", 64'(bsy[0]), 64'h1); chk("t1 ack", 64'(ack[0]), 64'h1);
      chk("t1 dat", 64'(dato[0]), 64'hdeadbeef); chk("t1 irq", 64'(irq[0]), 64'h1);
      chk("t1 fltaddr", 64'(fltaddr[0]), 64'h100);
      step(); neg(); chk("t1 ack end", 64'(ack[0]), 64'h0);

      // T2: ACKLAT4 write of word 0x10, sel 3
      step(); cyc[1] = 1; stb[1] = 1; we[1] = 1; addr[1] = 30'h10; sel[1] = 4'h3;
      step(); stb[1] = 0;
      neg();
      chk("t2 ack T+1", 64'(ack[1]), 64'h0); chk("t2 fltaddr", 64'(fltaddr[1]), 64'h40);
      chk("t2 fltwe", 64'(fltwe[1]), 64'h1); chk("t2 fltsel", 64'(fltsel[1]), 64'h3);
      step(); step(); neg(); chk("t2 ack T+3", 64'(ack[1]), 64'h0);
      step(); cyc[1] = 0;
      neg(); chk("t2 ack T+4", 64'(ack[1]), 64'h1); chk("t2 dat", 64'(dato[1]), 64'h0);
      step(); neg(); chk("t2 bsy T+5", 64'(bsy[1]), 64'h0);

      // T3: 2-bit counter saturates, first address sticks
      step(); clr[0] = 1;
      step(); clr[0] = 0;
      neg(); chk("t3 clr flt", 64'(flt[0]), 64'h0); chk("t3 clr cnt", 64'(fltcnt[0]), 64'h0);
      for (int i = 0; i < 5; i++) begin
         step(); cyc[0] = 1; stb[0] = 1; we[0] = 0; addr[0] = 30'(32'h20 + i);
         step(); cyc[0] = 0; stb[0] = 0;
         neg(); chk($sformatf("t3 cnt%0d", i), 64'(fltcnt[0]), 64'(exp_cnt[i]));
      end
      chk("t3 fltaddr", 64'(fltaddr[0]), 64'h80);

      // T4: clear and accept in the same cycle
      step(); clr[0] = 1; cyc[0] = 1; stb[0] = 1; we[0] = 1; addr[0] = 30'h30; sel[0] = 4'h5;
      step(); clr[0] = 0; cyc[0] = 0; stb[0] = 0;
      neg();
      chk("t4 flt", 64'(flt[0]), 64'h1); chk("t4 cnt", 64'(fltcnt[0]), 64'h1);
      chk("t4 fltaddr", 64'(fltaddr[0]), 64'hc0); chk("t4 fltsel", 64'(fltsel[0]), 64'h5);

      // Held request on ACKLAT1: accepted every other cycle
      step(); cyc[0] = 1; stb[0] = 1; we[0] = 0; addr[0] = 30'h31;
      step(); step(); step();
      step(); cyc[0] = 0; stb[0] = 0;
      neg(); chk("b2b cnt", 64'(fltcnt[0]), 64'h3); chk("b2b fltaddr", 64'(fltaddr[0]), 64'hc0);

      // T5: ACKLAT4, cyc dropped at T+2 aborts; new request at T+3
      step(); cyc[1] = 1; stb[1] = 1; we[1] = 0; addr[1] = 30'h50; sel[1] = 4'hf;
      step(); stb[1] = 0;
      step(); cyc[1] = 0;
      neg(); chk("t5 bsy T+2", 64'(bsy[1]), 64'h1);
      step(); cyc[1] = 1; stb[1] = 1; addr[1] = 30'h51;
      neg(); chk("t5 bsy T+3", 64'(bsy[1]), 64'h0); chk("t5 ack T+3", 64'(ack[1]), 64'h0);
      step(); stb[1] = 0;
      neg();
      chk("t5 ack T+4", 64'(ack[1]), 64'h0); chk("t5 bsy T+4", 64'(bsy[1]), 64'h1);
      chk("t5 cnt", 64'(fltcnt[1]), 64'h3);
      step(); step();
      neg(); chk("t5 ack T+6", 64'(ack[1]), 64'h0);
      step(); cyc[1] = 0;
      neg(); chk("t5 ack T+7", 64'(ack[1]), 64'h1); chk("t5 dat", 64'(dato[1]), 64'hdeadbeef);

      // T6: reset during an ACKLAT3 access
      step(); cyc[2] = 1; stb[2] = 1; we[2] = 0; addr[2] = 30'h60; sel[2] = 4'hf;
      step(); stb[2] = 0; rst[2] = 1;
      neg(); chk("t6 bsy T+1", 64'(bsy[2]), 64'h1); chk("t6 flt T+1", 64'(flt[2]), 64'h1);
      step(); rst[2] = 0;
      neg();
      chk("t6 bsy", 64'(bsy[2]), 64'h0); chk("t6 flt", 64'(flt[2]), 64'h0);
      chk("t6 fltaddr", 64'(fltaddr[2]), 64'h0); chk("t6 cnt", 64'(fltcnt[2]), 64'h0);
      step(); neg(); chk("t6 ack T+3", 64'(ack[2]), 64'h0);
      step(); cyc[2] = 0;
      neg(); chk("t6 ack T+4", 64'(ack[2]), 64'h0);
      step(); step();

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
